// File: rtl/weighted_round_robin_arbiter.sv
// Weighted round-robin arbiter: multi-beat transactions lock the grant, and an
// owner may keep the channel for up to its weight in back-to-back transactions.
module weighted_round_robin_arbiter #(
    parameter int SIZE         = 4,
    parameter int WEIGHT_WIDTH = 4,
    localparam int IDX_W       = (SIZE > 1) ? $clog2(SIZE) : 1
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [SIZE-1:0]              requests,
    input  logic [SIZE*WEIGHT_WIDTH-1:0] weights,
    input  logic                         last,
    input  logic                         ready,
    output logic [SIZE-1:0]              grant,
    output logic [IDX_W-1:0]             grant_index,
    output logic                         busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        pointer_q, pointer_d;
    logic [IDX_W-1:0]        owner_q, owner_d;
    logic [WEIGHT_WIDTH-1:0] credit_q, credit_d;

    logic                    pickValid;
    logic [IDX_W-1:0]        pickIdx;
    logic [IDX_W-1:0]        nextPointer;
    logic [WEIGHT_WIDTH-1:0] pickWeightRaw;
    logic [WEIGHT_WIDTH-1:0] effWeight;
    logic [WEIGHT_WIDTH-1:0] effWeightM1;
    logic [WEIGHT_WIDTH-1:0] creditDec;
    logic                    ownerReq;
    logic                    idleLike;
    logic                    transfer;
    logic [SIZE-1:0]         grantC;
    logic [IDX_W-1:0]        idxC;
    int                      cand;

    // Scan from the highest cyclic offset down so the nearest request to the pointer wins.
    always_comb begin
        pickValid = 1'b0;
        pickIdx   = '0;
        cand      = 0;
        for (int k = SIZE - 1; k >= 0; k--) begin
            cand = int'(pointer_q) + k;
            if (cand >= SIZE) cand = cand - SIZE;
            if (requests[cand]) begin
                pickValid = 1'b1;
                pickIdx   = IDX_W'(cand);
            end
        end
    end

    always_comb begin
        nextPointer   = (int'(pickIdx) == SIZE - 1) ? '0 : pickIdx + 1'b1;
        pickWeightRaw = weights[int'(pickIdx)*WEIGHT_WIDTH +: WEIGHT_WIDTH];
        effWeight     = (pickWeightRaw == '0) ? WEIGHT_WIDTH'(1) : pickWeightRaw;
        effWeightM1   = effWeight - 1'b1;
        creditDec     = (credit_q != '0) ? credit_q - 1'b1 : '0;
        ownerReq      = requests[owner_q];
    end

    // A HOLD whose owner has gone quiet arbitrates exactly like IDLE this cycle.
    always_comb begin
        state_d   = state_q;
        pointer_d = pointer_q;
        owner_d   = owner_q;
        credit_d  = credit_q;
        grantC    = '0;
        idxC      = '0;
        transfer  = 1'b0;
        idleLike  = (state_q == IDLE) || ((state_q == HOLD) && !ownerReq);

        if (idleLike) begin
            if (pickValid) begin
                grantC[pickIdx] = 1'b1;
                idxC            = pickIdx;
            end
            transfer = pickValid & ready;
            if (transfer) begin
                owner_d   = pickIdx;
                pointer_d = nextPointer;
                if (last) begin
                    credit_d = effWeightM1;
                    state_d  = (effWeightM1 != '0) ? HOLD : IDLE;
                end else begin
                    credit_d = effWeight;
                    state_d  = BUSY;
                end
            end else if (state_q == HOLD) begin
                state_d  = IDLE;
                credit_d = '0;
            end
        end else begin
            grantC[owner_q] = 1'b1;
            idxC            = owner_q;
            transfer        = ownerReq & ready;
            if (transfer) begin
                if (last) begin
                    credit_d = creditDec;
                    state_d  = (creditDec != '0) ? HOLD : IDLE;
                end else begin
                    state_d  = BUSY;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            pointer_q <= '0;
            owner_q   <= '0;
            credit_q  <= '0;
        end else begin
            state_q   <= state_d;
            pointer_q <= pointer_d;
            owner_q   <= owner_d;
            credit_q  <= credit_d;
        end
    end

    always_comb begin
        grant       = reset ? '0 : grantC;
        grant_index = reset ? '0 : idxC;
        busy        = !reset && (state_q != IDLE);
    end

endmodule
